// File: rtl/imm_gen_pkg.sv
// Shared constants for the ID-stage immediate generator.
// Immediate-type codes, unsigned-flag position and XLEN legality.
package imm_gen_pkg;

  localparam logic [2:0] IMM_U     = 3'd0;
  localparam logic [2:0] IMM_J     = 3'd1;
  localparam logic [2:0] IMM_I     = 3'd2;
  localparam logic [2:0] IMM_B     = 3'd3;
  localparam logic [2:0] IMM_S     = 3'd4;
  localparam logic [2:0] IMM_SHAMT = 3'd5;
  localparam logic [2:0] IMM_ZIMM  = 3'd6;
  localparam logic [2:0] IMM_NONE  = 3'd7;

  localparam int SEL_UNS = 3;

  function automatic bit xlen_ok(int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_gen_stage_imm_decode.sv
// Combinational RISC-V immediate decoder.
// Builds a 32-bit field, then widens it to XLEN with the extension bit.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [3:0]      sel,
  output logic [XLEN-1:0] imm
);

  logic [2:0]  typ;
  logic        sb;
  logic        ext;
  logic [31:0] raw;
  logic        unused_opc;

  assign typ        = sel[2:0];
  assign sb         = inst[31] & ~sel[SEL_UNS];
  assign unused_opc = ^inst[6:0];

  always_comb begin
    raw = '0;
    ext = 1'b0;
    unique case (1'b1)
      (typ == IMM_U): begin
        raw = {inst[31:12], 12'b0};
        ext = sb;
      end
      (typ == IMM_J): begin
        raw = {{11{sb}}, inst[31], inst[19:12],
               inst[20], inst[30:21], 1'b0};
        ext = sb;
      end
      (typ == IMM_I): begin
        raw = {{20{sb}}, inst[31:20]};
        ext = sb;
      end
      (typ == IMM_B): begin
        raw = {{19{sb}}, inst[31], inst[7],
               inst[30:25], inst[11:8], 1'b0};
        ext = sb;
      end
      (typ == IMM_S): begin
        raw = {{20{sb}}, inst[31:25], inst[11:7]};
        ext = sb;
      end
      (typ == IMM_SHAMT): begin
        // RV64 shifts carry a 6-bit amount
        raw = (XLEN == 32) ? {27'b0, inst[24:20]}
                           : {26'b0, inst[25:20]};
      end
      (typ == IMM_ZIMM): begin
        raw = {27'b0, inst[19:15]};
      end
      (typ == IMM_NONE): begin
        raw = '0;
      end
      default: begin
        raw = '0;
      end
    endcase
  end

  if (XLEN > 32) begin : g_wide
    assign imm = {{(XLEN-32){ext}}, raw};
  end else begin : g_narrow
    assign imm = raw[XLEN-1:0];
  end

endmodule

// File: rtl/imm_gen_stage.sv
// ID-stage immediate generator with a two-entry skid buffer.
// in_ready is a flop so the upstream path never sees our comb logic.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [3:0]       sel,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag
);

  if (!xlen_ok(XLEN)) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state;
  logic [XLEN-1:0]  dec_imm;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             acc;
  logic             emit;

  imm_decode #(
    .XLEN(XLEN)
  ) u_dec (
    .inst(inst),
    .sel (sel),
    .imm (dec_imm)
  );

  assign out_valid = (state != ST_EMPTY);
  assign acc       = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
      out_imm  <= '0;
      out_tag  <= '0;
      skid_imm <= '0;
      skid_tag <= '0;
    end else if (flush) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (acc) begin
            out_imm <= dec_imm;
            out_tag <= in_tag;
            state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (acc && emit) begin
            out_imm <= dec_imm;
            out_tag <= in_tag;
          end else if (acc) begin
            skid_imm <= dec_imm;
            skid_tag <= in_tag;
            state    <= ST_FULL;
            in_ready <= 1'b0;
          end else if (emit) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can happen
          if (emit) begin
            out_imm  <= skid_imm;
            out_tag  <= skid_tag;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_EMPTY;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus
// and are checked against an arithmetic decode model and a FIFO scoreboard.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] inst;
  logic [3:0]  sel;
  logic [7:0]  in_tag;
  logic        flush;
  logic        out_ready;

  logic        in_ready32, out_valid32;
  logic [31:0] out_imm32;
  logic [7:0]  out_tag32;
  logic        in_ready64, out_valid64;
  logic [63:0] out_imm64;
  logic [7:0]  out_tag64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] imm32;
    logic [63:0] imm64;
    logic [7:0]  tag;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready32),
    .inst(inst), .sel(sel), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_tag(out_tag32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64),
    .inst(inst), .sel(sel), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_tag(out_tag64)
  );

  function automatic longint unsigned fld(logic [31:0] i, int hi, int lo);
    return (64'(i) >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
  endfunction

  // Field value and its width, then two's-complement sign extension by subtraction
  function automatic logic [63:0] ref_imm(logic [31:0] i, logic [3:0] s, int xlen);
    longint unsigned v;
    int w;
    bit sx;
    sx = !s[3];
    w = 32;
    case (s[2:0])
      3'd0: begin v = fld(i, 31, 12) << 12; w = 32; end
      3'd1: begin
        v = (fld(i, 31, 31) << 20) + (fld(i, 19, 12) << 12)
          + (fld(i, 20, 20) << 11) + (fld(i, 30, 21) << 1);
        w = 21;
      end
      3'd2: begin v = fld(i, 31, 20); w = 12; end
      3'd3: begin
        v = (fld(i, 31, 31) << 12) + (fld(i, 7, 7) << 11)
          + (fld(i, 30, 25) << 5) + (fld(i, 11, 8) << 1);
        w = 13;
      end
      3'd4: begin v = (fld(i, 31, 25) << 5) + fld(i, 11, 7); w = 12; end
      3'd5: begin v = (xlen == 32) ? fld(i, 24, 20) : fld(i, 25, 20); sx = 0; end
      3'd6: begin v = fld(i, 19, 15); sx = 0; end
      default: begin v = 0; sx = 0; end
    endcase
    if (sx && v >= (64'd1 << (w - 1))) v = v - (64'd1 << w);
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic drive(bit v, logic [31:0] i, logic [3:0] s, logic [7:0] t);
    in_valid = v;
    inst     = i;
    sel      = s;
    in_tag   = t;
  endtask

  task automatic tick();
    bit acc, emit, clr;
    ent_t e;
    logic [63:0] r32;
    clr  = reset || flush;
    acc  = in_valid && (q.size() < 2);
    emit = (q.size() > 0) && out_ready;
    r32     = ref_imm(inst, sel, 32);
    e.imm32 = r32[31:0];
    e.imm64 = ref_imm(inst, sel, 64);
    e.tag   = in_tag;
    @(posedge clk);
    #1;
    if (clr) q.delete();
    else begin
      if (emit) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1; flush = 0; out_ready = 0;
    drive(0, 32'h0, 4'h0, 8'h0);
    tick(); tick();
    reset = 0;
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL rst_valid32 got %b want 0", out_valid32); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL rst_ready32 got %b want 1", in_ready32); end
    checks++; if (out_imm32 !== 32'h0) begin errors++; $display("FAIL rst_imm32 got %h want 0", out_imm32); end
    checks++; if (out_tag32 !== 8'h0) begin errors++; $display("FAIL rst_tag32 got %h want 0", out_tag32); end
    checks++; if (out_valid64 !== 1'b0) begin errors++; $display("FAIL rst_valid64 got %b want 0", out_valid64); end
    checks++; if (in_ready64 !== 1'b1) begin errors++; $display("FAIL rst_ready64 got %b want 1", in_ready64); end
    checks++; if (out_imm64 !== 64'h0) begin errors++; $display("FAIL rst_imm64 got %h want 0", out_imm64); end
  endtask

  task automatic test_decode_directed();
    logic [31:0] di [6];
    logic [3:0]  ds [6];
    logic [31:0] e32 [6];
    logic [63:0] e64 [6];
    di  = '{32'hFFF00093, 32'hFFF00093, 32'hFFDFF06F, 32'hFE000CE3, 32'h800000B7, 32'h03F01093};
    ds  = '{4'h2, 4'hA, 4'h1, 4'h3, 4'h0, 4'h5};
    e32 = '{32'hFFFFFFFF, 32'h00000FFF, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h80000000, 32'h0000001F};
    e64 = '{64'hFFFFFFFFFFFFFFFF, 64'h0000000000000FFF, 64'hFFFFFFFFFFFFFFFC,
            64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFF80000000, 64'h000000000000003F};
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      drive(1, di[k], ds[k], 8'(8'h10 + k));
      tick();
      drive(0, 32'h0, 4'h0, 8'h0);
      checks++; if (out_valid32 !== 1'b1) begin errors++; $display("FAIL dec_valid[%0d] got %b want 1", k, out_valid32); end
      checks++; if (out_imm32 !== e32[k]) begin errors++; $display("FAIL dec_imm32[%0d] got %h want %h", k, out_imm32, e32[k]); end
      checks++; if (out_imm64 !== e64[k]) begin errors++; $display("FAIL dec_imm64[%0d] got %h want %h", k, out_imm64, e64[k]); end
      checks++; if (out_tag32 !== 8'(8'h10 + k)) begin errors++; $display("FAIL dec_tag[%0d] got %h want %h", k, out_tag32, 8'(8'h10 + k)); end
      tick();
      checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL dec_drain[%0d] got %b want 0", k, out_valid32); end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    drive(1, 32'h00100093, 4'h2, 8'h01);
    tick();
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL b2b_ready_one got %b want 1", in_ready32); end
    drive(1, 32'h00200093, 4'h2, 8'h02);
    tick();
    drive(0, 32'h0, 4'h0, 8'h0);
    checks++; if (in_ready32 !== 1'b0) begin errors++; $display("FAIL b2b_ready_full32 got %b want 0", in_ready32); end
    checks++; if (in_ready64 !== 1'b0) begin errors++; $display("FAIL b2b_ready_full64 got %b want 0", in_ready64); end
    checks++; if (out_tag32 !== 8'h01) begin errors++; $display("FAIL b2b_hold_tag got %h want 01", out_tag32); end
    tick();
    checks++; if (out_tag32 !== 8'h01) begin errors++; $display("FAIL b2b_stall_tag got %h want 01", out_tag32); end
    checks++; if (out_imm32 !== 32'h1) begin errors++; $display("FAIL b2b_stall_imm got %h want 1", out_imm32); end
    out_ready = 1;
    tick();
    checks++; if (out_valid32 !== 1'b1) begin errors++; $display("FAIL b2b_second_valid got %b want 1", out_valid32); end
    checks++; if (out_tag32 !== 8'h02) begin errors++; $display("FAIL b2b_second_tag got %h want 02", out_tag32); end
    checks++; if (out_imm32 !== 32'h2) begin errors++; $display("FAIL b2b_second_imm got %h want 2", out_imm32); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got %b want 1", in_ready32); end
    tick();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b want 0", out_valid32); end
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive(1, 32'h12345093, 4'h2, 8'h31); tick();
    drive(1, 32'h23456093, 4'h2, 8'h32); tick();
    flush = 1;
    drive(1, 32'h34567093, 4'h2, 8'h33); tick();
    flush = 0;
    drive(0, 32'h0, 4'h0, 8'h0);
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL flush_valid32 got %b want 0", out_valid32); end
    checks++; if (out_valid64 !== 1'b0) begin errors++; $display("FAIL flush_valid64 got %b want 0", out_valid64); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", in_ready32); end
    out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL flush_ghost[%0d] got tag %h", k, out_tag32); end
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 0;
    drive(1, 32'hABCDE093, 4'h2, 8'h41); tick();
    drive(1, 32'hBCDEF093, 4'h2, 8'h42); tick();
    reset = 1;
    drive(1, 32'hCDEF0093, 4'h2, 8'h43); tick();
    reset = 0;
    drive(0, 32'h0, 4'h0, 8'h0);
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b want 0", out_valid32); end
    checks++; if (in_ready32 !== 1'b1) begin errors++; $display("FAIL mrst_ready got %b want 1", in_ready32); end
    checks++; if (out_imm32 !== 32'h0) begin errors++; $display("FAIL mrst_imm32 got %h want 0", out_imm32); end
    checks++; if (out_imm64 !== 64'h0) begin errors++; $display("FAIL mrst_imm64 got %h want 0", out_imm64); end
    checks++; if (out_tag64 !== 8'h0) begin errors++; $display("FAIL mrst_tag got %h want 0", out_tag64); end
    out_ready = 1;
    drive(1, 32'hFFF00093, 4'h2, 8'h55); tick();
    drive(0, 32'h0, 4'h0, 8'h0);
    checks++; if (out_valid32 !== 1'b1) begin errors++; $display("FAIL mrst_lat_valid got %b want 1", out_valid32); end
    checks++; if (out_tag32 !== 8'h55) begin errors++; $display("FAIL mrst_lat_tag got %h want 55", out_tag32); end
    checks++; if (out_imm32 !== 32'hFFFFFFFF) begin errors++; $display("FAIL mrst_lat_imm got %h want ffffffff", out_imm32); end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] tg;
    tg = 8'h80;
    for (int c = 0; c < 600; c++) begin
      checks++; if (out_valid32 !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid32 @%0d got %b want %b", c, out_valid32, q.size() > 0); end
      checks++; if (out_valid64 !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid64 @%0d got %b want %b", c, out_valid64, q.size() > 0); end
      checks++; if (in_ready32 !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready32 @%0d got %b want %b", c, in_ready32, q.size() < 2); end
      checks++; if (in_ready64 !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready64 @%0d got %b want %b", c, in_ready64, q.size() < 2); end
      if (q.size() > 0) begin
        checks++; if (out_imm32 !== q[0].imm32) begin errors++; $display("FAIL rnd_imm32 @%0d got %h want %h", c, out_imm32, q[0].imm32); end
        checks++; if (out_imm64 !== q[0].imm64) begin errors++; $display("FAIL rnd_imm64 @%0d got %h want %h", c, out_imm64, q[0].imm64); end
        checks++; if (out_tag32 !== q[0].tag) begin errors++; $display("FAIL rnd_tag32 @%0d got %h want %h", c, out_tag32, q[0].tag); end
        checks++; if (out_tag64 !== q[0].tag) begin errors++; $display("FAIL rnd_tag64 @%0d got %h want %h", c, out_tag64, q[0].tag); end
      end
      drive($urandom_range(0, 99) < 65, $urandom, 4'($urandom_range(0, 15)), tg);
      if (in_valid && q.size() < 2) tg = tg + 8'h1;
      out_ready = $urandom_range(0, 99) < 60;
      flush     = $urandom_range(0, 99) < 4;
      tick();
      flush = 0;
    end
    drive(0, 32'h0, 4'h0, 8'h0);
    out_ready = 1;
    tick(); tick(); tick();
    checks++; if (out_valid32 !== 1'b0) begin errors++; $display("FAIL rnd_drain got %b want 0", out_valid32); end
  endtask

  initial begin
    reset = 1; flush = 0; out_ready = 0;
    drive(0, 32'h0, 4'h0, 8'h0);
    test_reset();
    test_decode_directed();
    test_back_to_back();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
